ps2_keyboard_ctrl: RTL and testbench
====================================

Name: ps2_keyboard_ctrl

Overview:
- Parametrised PS/2 keyboard receiver: synchronises ps2_clk/ps2_data into the system clock domain and checks the full 11-bit frame (start, parity, stop).
- Decodes E0/F0 prefix sequences into make/break events and buffers them in an event FIFO with a valid/ready handshake.
- Maintains a level-held arrow-key bitmap. Sits between the PS/2 pins and game/menu control logic.

Parameters:
- SYNC_STAGES, 2, flip-flop stages on ps2_clk and ps2_data (min 2).
- TIMEOUT_CYCLES, 100000, clk cycles without a PS/2 falling edge, mid-frame, before the frame is aborted.
- FIFO_DEPTH, 8, event FIFO entries (power of 2, min 2).

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- ps2_clk  input  1  PS/2 clock line (asynchronous)
- ps2_data  input  1  PS/2 data line (asynchronous)
- action  output  4  held-key bitmap: [0] up, [1] down, [2] left, [3] right
- ev_valid  output  1  FIFO head event valid
- ev_ready  input  1  consumer accepts head event
- ev_code  output  8  scancode of head event
- ev_ext  output  1  head event carried E0 prefix
- ev_break  output  1  head event is a release (F0)
- parity_err  output  1  one-cycle pulse: bad parity
- frame_err  output  1  one-cycle pulse: bad start/stop or timeout
- overflow  output  1  one-cycle pulse: event dropped, FIFO full

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset: all outputs 0, FIFO empty, bit counter 0, decode FSM IDLE, timeout counter 0, synchroniser flops reset to 1.
- Edge detect: a falling edge is registered on the cycle the synchronised ps2_clk goes 1->0. ps2_data is sampled from the synchroniser on that same cycle.
- Frame layout:
  - bit0 start, must be 0
  - bits1-8 data, LSB first
  - bit9 odd parity over data+parity
  - bit10 stop, must be 1
- Byte completion: let E be the cycle of the bit10 falling edge.
  - Valid frame: byte strobe at E+1.
  - Bad parity: parity_err pulse at E+1, no strobe.
  - Bad start or stop: frame_err pulse at E+1, no strobe.
  - Any error also returns the FSM to IDLE.
- Timeout: the counter runs while bit count is 1..10 and clears on every falling edge. When it reaches TIMEOUT_CYCLES:
  - bit count goes to 0
  - frame_err pulses
  - FSM goes to IDLE
- Decode FSM: states IDLE, E0, F0, E0F0. On each byte strobe:
  - IDLE: E0->E0; F0->F0; other byte->push {code, ext=0, brk=0}
  - E0: F0->E0F0; E0->E0; other byte->push {code, ext=1, brk=0}, ->IDLE
  - F0: byte->push {code, ext=0, brk=1}, ->IDLE
  - E0F0: byte->push {code, ext=1, brk=1}, ->IDLE
  - Prefix bytes are never pushed.
- Push timing: the push happens at E+1. ev_valid rises at E+2 when the FIFO was empty.
- Handshake: a pop occurs when ev_valid && ev_ready; the head advances on the next cycle.
- FIFO full:
  - A push with no same-cycle pop is dropped and overflow pulses at that cycle.
  - A push and pop in the same cycle while full both succeed.
  - Empty FIFO: ev_valid=0; ev_code/ev_ext/ev_break hold their last values.
- action: updated at E+2 from the decoded event, regardless of FIFO space. Codes 75/72/6B/74 map to up/down/left/right, with or without E0.
  - A make sets the bit; a break clears only that bit.
  - Multiple bits may be high at once.
  - Other codes leave action unchanged.
- Reset mid-frame: the partial byte is discarded and no error pulse is generated.

Optional Feature:
- Macro: PS2_KBD_TYPEMATIC_FILTER_EN.
- Defined: the block keeps a last-make register {code, ext, valid}.
  - A make whose code and ext both match the last-make register is not pushed (typematic repeat suppressed).
  - Any break, or any non-matching make, updates or clears the register.
  - action is unaffected.
- Undefined: every make, including repeats, is pushed.

Test Plan:
- Frames E0,75 -> FIFO event {75, ext=1, brk=0}, action=0001. Then E0,F0,75 -> event {75, 1, 1}, action=0000.
- Make 75, then make 6B, then F0,75 -> action goes 0001 -> 0101 -> 0100. Three events in order.
- Frame 1C with parity bit inverted -> parity_err one pulse at E+1, no event. A following valid 1C -> event {1C, 0, 0}.
- Five bits sent, then idle for TIMEOUT_CYCLES -> one frame_err pulse. The next full frame 29 decodes to event {29, 0, 0}.
- ev_ready=0, FIFO_DEPTH+1 make frames 15,16,... -> overflow pulses once. Draining gives the first FIFO_DEPTH codes in order. A push+pop in the same cycle while full loses no event.
- Filter on: 75 sent three times, then F0,75 -> two events (make, break). Filter off -> four events.

Source files
------------

// File: rtl/ps2_keyboard_ctrl.sv
// PS/2 keyboard receiver: frame checking, E0/F0 decode, event FIFO and arrow-key bitmap.
// Optional typematic repeat suppression is enabled by defining PS2_KBD_TYPEMATIC_FILTER_EN.
module ps2_keyboard_ctrl #(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int FIFO_DEPTH     = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [3:0] action,
  output logic       ev_valid,
  input  logic       ev_ready,
  output logic [7:0] ev_code,
  output logic       ev_ext,
  output logic       ev_break,
  output logic       parity_err,
  output logic       frame_err,
  output logic       overflow
);

  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int AW   = $clog2(FIFO_DEPTH);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_E0   = 2'd1;
  localparam logic [1:0] ST_F0   = 2'd2;
  localparam logic [1:0] ST_E0F0 = 2'd3;

  // Arrow scancodes, bit i of action maps to byte i: up, down, left, right.
  localparam logic [31:0] ARROW_CODES = {8'h74, 8'h6B, 8'h72, 8'h75};

  // ---------------------------------------------------------------------------
  // Synchroniser and falling-edge detect
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] clk_sync_reg;
  logic [SYNC_STAGES-1:0] data_sync_reg;
  logic                   clk_prev_reg;
  logic                   clk_s;
  logic                   data_s;
  logic                   fall;

  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync_reg  <= '1;
      data_sync_reg <= '1;
      clk_prev_reg  <= 1'b1;
    end else begin
      clk_sync_reg  <= {clk_sync_reg[SYNC_STAGES-2:0], ps2_clk};
      data_sync_reg <= {data_sync_reg[SYNC_STAGES-2:0], ps2_data};
      clk_prev_reg  <= clk_s;
    end
  end

  assign clk_s  = clk_sync_reg[SYNC_STAGES-1];
  assign data_s = data_sync_reg[SYNC_STAGES-1];
  assign fall   = clk_prev_reg & ~clk_s;

  // ---------------------------------------------------------------------------
  // Frame assembly, checking and timeout
  // ---------------------------------------------------------------------------
  logic [3:0]      bit_cnt_reg;
  logic [9:0]      frame_reg;
  logic [TO_W-1:0] to_cnt_reg;
  logic            strobe_reg;
  logic [7:0]      byte_reg;
  logic            parity_err_reg;
  logic            frame_err_reg;

  // After ten right shifts: [0] start, [8:1] data, [9] parity; stop is sampled live.
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt_reg    <= '0;
      frame_reg      <= '0;
      to_cnt_reg     <= '0;
      strobe_reg     <= 1'b0;
      byte_reg       <= '0;
      parity_err_reg <= 1'b0;
      frame_err_reg  <= 1'b0;
    end else begin
      strobe_reg     <= 1'b0;
      parity_err_reg <= 1'b0;
      frame_err_reg  <= 1'b0;
      if (fall) begin
        to_cnt_reg <= '0;
        if (bit_cnt_reg == 4'd10) begin
          bit_cnt_reg <= '0;
          byte_reg    <= frame_reg[8:1];
          if (frame_reg[0] || !data_s) begin
            frame_err_reg <= 1'b1;
          end else if (!(^frame_reg[9:1])) begin
            parity_err_reg <= 1'b1;
          end else begin
            strobe_reg <= 1'b1;
          end
        end else begin
          bit_cnt_reg <= bit_cnt_reg + 4'd1;
          frame_reg   <= {data_s, frame_reg[9:1]};
        end
      end else if (bit_cnt_reg != 4'd0) begin
        if (to_cnt_reg == TO_W'(TIMEOUT_CYCLES - 1)) begin
          to_cnt_reg    <= '0;
          bit_cnt_reg   <= '0;
          frame_err_reg <= 1'b1;
        end else begin
          to_cnt_reg <= to_cnt_reg + 1'b1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Prefix decode FSM
  // ---------------------------------------------------------------------------
  logic [1:0] state_reg;
  logic [1:0] state_next;
  logic       ev_req;
  logic       ev_ext_d;
  logic       ev_brk_d;

  always_comb begin
    state_next = state_reg;
    ev_req     = 1'b0;
    ev_ext_d   = 1'b0;
    ev_brk_d   = 1'b0;
    if (parity_err_reg || frame_err_reg) begin
      state_next = ST_IDLE;
    end else if (strobe_reg) begin
      case (state_reg)
        ST_IDLE: begin
          if (byte_reg == 8'hE0)      state_next = ST_E0;
          else if (byte_reg == 8'hF0) state_next = ST_F0;
          else                        ev_req     = 1'b1;
        end
        ST_E0: begin
          if (byte_reg == 8'hF0) begin
            state_next = ST_E0F0;
          end else if (byte_reg == 8'hE0) begin
            state_next = ST_E0;
          end else begin
            ev_req     = 1'b1;
            ev_ext_d   = 1'b1;
            state_next = ST_IDLE;
          end
        end
        ST_F0: begin
          ev_req     = 1'b1;
          ev_brk_d   = 1'b1;
          state_next = ST_IDLE;
        end
        default: begin
          ev_req     = 1'b1;
          ev_ext_d   = 1'b1;
          ev_brk_d   = 1'b1;
          state_next = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_reg <= ST_IDLE;
    else     state_reg <= state_next;
  end

  // ---------------------------------------------------------------------------
  // Held-key bitmap, fed by every decoded event whether or not it is queued
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_action
      logic held_reg;
      always_ff @(posedge clk) begin
        if (rst) begin
          held_reg <= 1'b0;
        end else if (ev_req && byte_reg == ARROW_CODES[gi*8 +: 8]) begin
          held_reg <= !ev_brk_d;
        end
      end
      assign action[gi] = held_reg;
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Typematic repeat filter
  // ---------------------------------------------------------------------------
  logic push_req;

`ifdef PS2_KBD_TYPEMATIC_FILTER_EN
  logic [7:0] last_code_reg;
  logic       last_ext_reg;
  logic       last_valid_reg;
  logic       repeat_hit;

  assign repeat_hit = ev_req && !ev_brk_d && last_valid_reg &&
                      (last_code_reg == byte_reg) && (last_ext_reg == ev_ext_d);
  assign push_req   = ev_req && !repeat_hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      last_code_reg  <= '0;
      last_ext_reg   <= 1'b0;
      last_valid_reg <= 1'b0;
    end else if (ev_req) begin
      if (ev_brk_d) begin
        last_valid_reg <= 1'b0;
      end else begin
        last_code_reg  <= byte_reg;
        last_ext_reg   <= ev_ext_d;
        last_valid_reg <= 1'b1;
      end
    end
  end
`else
  assign push_req = ev_req;
`endif

  // ---------------------------------------------------------------------------
  // Event FIFO with registered head
  // ---------------------------------------------------------------------------
  logic [9:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [AW-1:0] rd_ptr_next;
  logic [AW:0]   count_reg;
  logic [AW:0]   count_next;
  logic          ev_valid_reg;
  logic [9:0]    head_reg;
  logic [9:0]    push_word;
  logic          full;
  logic          pop;
  logic          do_push;

  assign push_word   = {byte_reg, ev_ext_d, ev_brk_d};
  assign full        = (count_reg == (AW+1)'(FIFO_DEPTH));
  assign pop         = ev_valid_reg && ev_ready;
  assign do_push     = push_req && (!full || pop);
  assign overflow    = push_req && full && !pop;
  assign rd_ptr_next = pop ? rd_ptr_reg + 1'b1 : rd_ptr_reg;
  assign count_next  = count_reg + (AW+1)'(do_push) - (AW+1)'(pop);

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= push_word;
  end

  // The slot that becomes head may be the one written this cycle, so bypass it.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      ev_valid_reg <= 1'b0;
      head_reg     <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      rd_ptr_reg   <= rd_ptr_next;
      count_reg    <= count_next;
      ev_valid_reg <= (count_next != '0);
      if (count_next != '0) begin
        if (do_push && wr_ptr_reg == rd_ptr_next) head_reg <= push_word;
        else                                      head_reg <= mem[rd_ptr_next];
      end
    end
  end

  assign ev_valid   = ev_valid_reg;
  assign ev_code    = head_reg[9:2];
  assign ev_ext     = head_reg[1];
  assign ev_break   = head_reg[0];
  assign parity_err = parity_err_reg;
  assign frame_err  = frame_err_reg;

endmodule

// File: tb/tb_ps2_keyboard_ctrl.sv
// Scoreboard bench for ps2_keyboard_ctrl: directed PS/2 frames, expected events queued
// at issue time and compared by an independent monitor on each handshake.
module tb_ps2_keyboard_ctrl;
  localparam int HALF  = 20;
  localparam int TO    = 600;
  localparam int DEPTH = 8;
`ifdef PS2_KBD_TYPEMATIC_FILTER_EN
  localparam bit FILT = 1'b1;
`else
  localparam bit FILT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       ev_ready = 1'b1;
  logic [3:0] action;
  logic       ev_valid;
  logic [7:0] ev_code;
  logic       ev_ext;
  logic       ev_break;
  logic       parity_err;
  logic       frame_err;
  logic       overflow;

  always #5 clk = ~clk;

  ps2_keyboard_ctrl #(
    .SYNC_STAGES(2), .TIMEOUT_CYCLES(TO), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .action(action), .ev_valid(ev_valid), .ev_ready(ev_ready),
    .ev_code(ev_code), .ev_ext(ev_ext), .ev_break(ev_break),
    .parity_err(parity_err), .frame_err(frame_err), .overflow(overflow)
  );

  int checks = 0;
  int failures = 0;
  int perr_cnt = 0;
  int ferr_cnt = 0;
  int ovf_cnt = 0;
  logic [9:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end else begin
      $display("ok   %s value=%0h", name, act);
    end
  endtask

  // Monitor: one line per accepted event, compared against the queue head.
  always @(negedge clk) begin
    if (!rst) begin
      if (parity_err) perr_cnt++;
      if (frame_err)  ferr_cnt++;
      if (overflow)   ovf_cnt++;
      if (ev_valid && ev_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_event actual=%0h required=none", {ev_code, ev_ext, ev_break});
        end else begin
          check("event", {22'd0, ev_code, ev_ext, ev_break}, {22'd0, exp_q.pop_front()});
        end
      end
    end
  end

  task automatic ps2_bit(input logic b);
    @(negedge clk); ps2_data = b;
    repeat (HALF) @(negedge clk); ps2_clk = 1'b0;
    repeat (HALF) @(negedge clk); ps2_clk = 1'b1;
  endtask

  // sync_pop opens ev_ready for exactly the cycle the final byte is pushed.
  task automatic send_byte(input logic [7:0] b, input logic bad_par, input logic sync_pop);
    logic [10:0] f;
    f = {1'b1, (~(^b)) ^ bad_par, b, 1'b0};
    for (int i = 0; i < 10; i++) ps2_bit(f[i]);
    @(negedge clk); ps2_data = f[10];
    repeat (HALF) @(negedge clk); ps2_clk = 1'b0;
    if (sync_pop) begin
      repeat (3) @(posedge clk);
      #1 ev_ready = 1'b1;
      @(posedge clk);
      #1 ev_ready = 1'b0;
    end
    repeat (HALF) @(negedge clk); ps2_clk = 1'b1;
    repeat (2 * HALF) @(negedge clk);
  endtask

  task automatic key(input logic [7:0] code, input logic ext, input logic brk, input logic expect_push);
    if (ext) send_byte(8'hE0, 1'b0, 1'b0);
    if (brk) send_byte(8'hF0, 1'b0, 1'b0);
    if (expect_push) exp_q.push_back({code, ext, brk});
    send_byte(code, 1'b0, 1'b0);
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 2000 && exp_q.size() != 0; i++) @(negedge clk);
    repeat (4) @(negedge clk);
    check(name, exp_q.size(), 0);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (4) @(negedge clk);
    check("reset_action", action, 4'b0000);
    check("reset_valid", ev_valid, 1'b0);
    check("reset_head", {ev_code, ev_ext, ev_break}, 10'h000);
    check("reset_errs", {parity_err, frame_err, overflow}, 3'b000);
    rst = 1'b0;
    repeat (10) @(negedge clk);

    // Extended make and break of up arrow.
    key(8'h75, 1'b1, 1'b0, 1'b1);
    check("e0_make_action", action, 4'b0001);
    key(8'h75, 1'b1, 1'b1, 1'b1);
    check("e0_break_action", action, 4'b0000);

    // Overlapping held keys.
    key(8'h75, 1'b0, 1'b0, 1'b1);
    check("up_action", action, 4'b0001);
    key(8'h6B, 1'b0, 1'b0, 1'b1);
    check("up_left_action", action, 4'b0101);
    key(8'h75, 1'b0, 1'b1, 1'b1);
    check("left_only_action", action, 4'b0100);
    key(8'h6B, 1'b0, 1'b1, 1'b1);
    check("none_action", action, 4'b0000);

    // Bad parity then a good frame.
    send_byte(8'h1C, 1'b1, 1'b0);
    check("parity_err_pulses", perr_cnt, 1);
    check("no_frame_err", ferr_cnt, 0);
    key(8'h1C, 1'b0, 1'b0, 1'b1);

    // Truncated frame times out.
    for (int i = 0; i < 5; i++) ps2_bit(i == 0 ? 1'b0 : 1'b1);
    repeat (TO + 50) @(negedge clk);
    check("timeout_frame_err", ferr_cnt, 1);
    key(8'h29, 1'b0, 1'b0, 1'b1);
    wait_drain("drain_basic");

    // Fill with consumer stalled, overflow once, then push+pop while full.
    @(posedge clk); #1 ev_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) key(8'h15 + 8'(i), 1'b0, 1'b0, 1'b1);
    check("full_valid", ev_valid, 1'b1);
    check("full_head", ev_code, 8'h15);
    key(8'h15 + 8'(DEPTH), 1'b0, 1'b0, 1'b0);
    check("overflow_pulses", ovf_cnt, 1);
    exp_q.push_back({8'h21, 1'b0, 1'b0});
    send_byte(8'h21, 1'b0, 1'b1);
    check("no_overflow_on_pushpop", ovf_cnt, 1);
    check("head_after_pushpop", ev_code, 8'h16);
    @(posedge clk); #1 ev_ready = 1'b1;
    wait_drain("drain_full");
    check("empty_valid", ev_valid, 1'b0);
    check("empty_head_hold", ev_code, 8'h21);

    // Typematic repeats then a break.
    for (int i = 0; i < 3; i++) key(8'h75, 1'b0, 1'b0, (i == 0) || !FILT);
    check("repeat_action", action, 4'b0001);
    key(8'h75, 1'b0, 1'b1, 1'b1);
    check("repeat_break_action", action, 4'b0000);
    wait_drain("drain_repeat");
    check("final_parity_errs", perr_cnt, 1);
    check("final_frame_errs", ferr_cnt, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
